// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the data-memory access sequencer:
//   - memOp width encodings driven by the control decoder
//   - FSM state encodings for dmem_seq
//   - is_misaligned(): alignment rule for an access width / low address bits
// No ports (package).
// ----------------------------------------------------------------------------
package mips_pkg;

    typedef logic [1:0] mem_op_t;

    localparam mem_op_t MEM_BYTE = 2'b00;
    localparam mem_op_t MEM_HALF = 2'b01;
    localparam mem_op_t MEM_WORD = 2'b10;   // 2'b11 is also handled as a word

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_REQ  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Halves need an even address and words a multiple of four.
    // Bytes are always aligned.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] addr_lo);
        logic mis;
        case (op)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = addr_lo[0];
            default:  mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_seq_if.sv
// ----------------------------------------------------------------------------
// dmem_seq_if
// Bus between the access sequencer (master) and the data memory (slave).
//   dm_req_o    master->slave  request valid; held until dm_ack_i
//   dm_we_o     master->slave  1 = write
//   dm_addr_o   master->slave  word-aligned byte address
//   dm_be_o     master->slave  byte enables
//   dm_wdata_o  master->slave  lane-replicated store data
//   dm_ack_i    slave->master  access accepted/completed this cycle
//   dm_rdata_i  slave->master  read word, valid together with dm_ack_i
//
// Handshake: dm_req_o acts as "valid" and dm_ack_i as "ready". Once the master
// raises dm_req_o, it keeps dm_req_o and every other master-driven field stable
// until the cycle in which dm_ack_i is high; that cycle is the transfer, and
// dm_rdata_i is sampled in it. dm_ack_i is meaningless while dm_req_o is low.
// ----------------------------------------------------------------------------
interface dmem_seq_if #(
    parameter int AW = 32
);
    logic          dm_req_o;
    logic          dm_we_o;
    logic [AW-1:0] dm_addr_o;
    logic [3:0]    dm_be_o;
    logic [31:0]   dm_wdata_o;
    logic          dm_ack_i;
    logic [31:0]   dm_rdata_i;

    modport master (
        output dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
        input  dm_ack_i, dm_rdata_i
    );

    modport slave (
        input  dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
        output dm_ack_i, dm_rdata_i
    );
endinterface

// File: rtl/dmem_align.sv
// ----------------------------------------------------------------------------
// dmem_align
// Combinational lane logic for a byte/half/word access.
//   op_i       in  2   memOp width (MEM_BYTE/HALF/WORD, 11 = word)
//   addr_lo_i  in  2   byte address bits [1:0]
//   sext_i     in  1   1 = sign-extend loaded byte/half
//   wdata_i    in  32  raw store data
//   rdata_i    in  32  raw word from memory
//   be_o       out 4   byte enables
//   wdata_o    out 32  store data replicated across all lanes
//   rdata_o    out 32  selected lane, extended to 32 bits
// ----------------------------------------------------------------------------
module dmem_align
    import mips_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Bring the addressed byte down to bit 0; halves pick the upper or lower pair.
    assign shifted = rdata_i >> {addr_lo_i, 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (op_i)
            MEM_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext_i & ld_byte[7]}}, ld_byte};
            end
            MEM_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sext_i & ld_half[15]}}, ld_half};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_seq.sv
// ----------------------------------------------------------------------------
// dmem_seq
// Multi-cycle data-memory access sequencer between the EX stage and a req/ack
// data memory. Runs one bus transaction per load/store and stalls the CPU
// until it completes.
//   clk, rstn                  clock (rising edge), async active-low reset
//   mem_rd_i / mem_wr_i        load / store present (store wins if both)
//   mem_op_i, mem_sext_i       access width, sign-extend flag for loads
//   addr_i, wdata_i            effective byte address, store data
//   stall_o                    freeze PC / pipeline registers
//   done_o                     one-cycle completion pulse, rdata_o valid
//   rdata_o                    aligned, extended load data (0 for stores)
//   misalign_o                 one-cycle pulse: misaligned access rejected
//   err_o                      one-cycle pulse with done_o on bus timeout
//   dbg_state_o                current FSM state (S_IDLE/S_REQ/S_DONE)
//   dm                         memory bus (dmem_seq_if.master)
// Build option: define DMEM_TIMEOUT_EN to abort a request after TIMEOUT_CYC
// REQ cycles without ack; otherwise REQ waits indefinitely and err_o is 0.
// ----------------------------------------------------------------------------
module dmem_seq
    import mips_pkg::*;
#(
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          mem_rd_i,
    input  logic          mem_wr_i,
    input  mem_op_t       mem_op_i,
    input  logic          mem_sext_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic          stall_o,
    output logic          done_o,
    output logic [31:0]   rdata_o,
    output logic          misalign_o,
    output logic          err_o,
    output state_t        dbg_state_o,
    dmem_seq_if.master    dm
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    mem_op_t       op_q, op_d;
    logic          sext_q, sext_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          start;
    logic          misal;
    logic          go;
    logic          in_req;
    logic          timeout;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [31:0]   al_rdata;

    // Gating with rstn keeps the combinational stall/misalign outputs at 0
    // while reset is held, even if the decoder still presents an instruction.
    assign start  = rstn & (mem_rd_i | mem_wr_i);
    assign misal  = is_misaligned(mem_op_i, addr_i[1:0]);
    assign go     = (state_q == S_IDLE) & start & ~misal;
    assign in_req = (state_q == S_REQ);

    // Lane logic always works from the latched request so the bus fields stay
    // stable for the whole REQ phase.
    dmem_align u_align (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .sext_i    (sext_q),
        .wdata_i   (wdata_q),
        .rdata_i   (dm.dm_rdata_i),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q is the number of REQ cycles already completed, so the request has
    // used up its budget in the REQ cycle where cnt_q reaches TIMEOUT_CYC-1.
    always_comb begin
        cnt_d = cnt_q;
        if (go) begin
            cnt_d = '0;
        end else if (in_req) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout = in_req & ~dm.dm_ack_i & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        sext_d  = sext_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_REQ;
                    addr_d  = addr_i;
                    op_d    = mem_op_i;
                    sext_d  = mem_sext_i;
                    we_d    = mem_wr_i;
                    wdata_d = wdata_i;
                    err_d   = 1'b0;
                end
            end
            S_REQ: begin
                if (dm.dm_ack_i) begin
                    state_d = S_DONE;
                    rdata_d = we_q ? 32'h0 : al_rdata;
                    err_d   = 1'b0;
                end else if (timeout) begin
                    state_d = S_DONE;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                // New requests are ignored here; the CPU re-presents next cycle.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            op_q    <= MEM_BYTE;
            sext_q  <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            sext_q  <= sext_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign stall_o     = go | in_req;
    assign done_o      = (state_q == S_DONE);
    assign err_o       = done_o & err_q;
    assign misalign_o  = (state_q == S_IDLE) & start & misal;
    assign rdata_o     = rdata_q;
    assign dbg_state_o = state_q;

    // Bus fields are forced to 0 outside REQ so the bus is quiet when idle.
    assign dm.dm_req_o   = in_req;
    assign dm.dm_we_o    = in_req & we_q;
    assign dm.dm_addr_o  = in_req ? {addr_q[AW-1:2], 2'b00} : '0;
    assign dm.dm_be_o    = in_req ? al_be : 4'b0000;
    assign dm.dm_wdata_o = in_req ? al_wdata : 32'h0;

endmodule
